pattern_serializer: RTL and testbench
=====================================

Name: pattern_serializer

Overview:
Transmit-side companion to the team's serial sequence detectors. Accepts a parallel bit pattern of programmable length through a valid/ready handshake. Shifts the pattern out MSB-first, one bit per clock, on a single serial line with a qualifying valid strobe. Optionally repeats the pattern a programmable number of times, with idle gap cycles between repetitions. Used to drive detector blocks in system and loopback tests.

Parameters:
DATA_W, 8, maximum pattern length in bits (width of pat_data)
LEN_W, 4, width of pat_len; must satisfy 2**LEN_W > DATA_W
REP_W, 3, width of pat_rep (repeat count)
GAP_CYCLES, 2, idle cycles inserted between repetitions; 0 allowed (back-to-back)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
pat_valid  input  1  pattern request valid
pat_ready  output  1  block can accept a pattern (high only in IDLE)
pat_data  input  DATA_W  pattern; low pat_len bits used, bit [pat_len-1] sent first
pat_len  input  LEN_W  number of bits to send; 0..DATA_W, larger values clamped to DATA_W
pat_rep  input  REP_W  extra repetitions; pattern is sent pat_rep+1 times
ser_out  output  1  serial data bit
ser_valid  output  1  ser_out carries a pattern bit this cycle
ser_last  output  1  final bit of final repetition
busy  output  1  transfer in progress (state != IDLE)
done  output  1  one-cycle pulse when a transfer completes

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; pat_ready=1; ser_out=0, ser_valid=0, ser_last=0, busy=0, done=0; counters and shift register cleared. Reset asserted mid-transfer aborts it; no done pulse.
- All outputs are registered, except pat_ready, which is decoded from state.
- States:
  - IDLE: pat_ready=1. On pat_valid&&pat_ready at edge T:
    - latch data, clamped length L and rep count R;
    - go to SHIFT, or to ZERO if L==0.
  - SHIFT: cycles T+1..T+L drive ser_valid=1 and ser_out = pat_data[L-1], pat_data[L-2], ..., pat_data[0].
    - After the last bit: if repetitions remain, go to GAP, or straight to the next SHIFT if GAP_CYCLES==0.
    - Otherwise go to IDLE.
  - GAP: exactly GAP_CYCLES cycles with ser_valid=0, ser_out=0, busy=1. Then SHIFT reloads the latched pattern and decrements the remaining-rep count.
  - ZERO: one cycle with done=1, ser_valid=0, then IDLE.
- ser_last=1 and done=1 together in the cycle carrying the final bit of the final repetition.
- ser_out=0 whenever ser_valid=0.
- Total busy cycles for L>0: (R+1)*L + R*GAP_CYCLES. pat_ready returns high the cycle after done.
- pat_valid while busy is ignored; the request is not queued, and the source must hold it until pat_ready.
- pat_data, pat_len and pat_rep changing after acceptance have no effect.
- L==1: each repetition is a single valid cycle.
- R at maximum (2**REP_W-1): the rep counter must not wrap; exactly 2**REP_W repetitions are sent.

Decomposition:
- Shared package (pattern_pkg):
  - state encoding constants IDLE=0, SHIFT=1, GAP=2, ZERO=3 (2-bit);
  - default DATA_W/LEN_W/REP_W;
  - the length clamp function.
- One natural sub-module, pattern_shift_reg: loadable MSB-first shift register with bit counter and last-bit flag. The top level holds the FSM, rep counter and gap counter.

Test Plan:
- Reset, then pat_data=8'h09, pat_len=4, pat_rep=0 accepted at T -> ser_valid=1 at T+1..T+4 with ser_out=1,0,0,1; ser_last=done=1 at T+4; pat_ready=1 at T+5.
- pat_data=8'h05, len=3, rep=2, GAP_CYCLES=2 -> bits 1,0,1, gap 0,0, 1,0,1, gap 0,0, 1,0,1; busy for 13 cycles; single done on the 13th.
- pat_len=0, rep=3 -> no ser_valid; done pulse at T+1; pat_ready=1 at T+2.
- pat_len=12 with DATA_W=8, pat_data=8'hA5 -> 8 bits 1,0,1,0,0,1,0,1 sent (clamped).
- reset driven low at T+2 of a 4-bit transfer, asynchronous to clk -> ser_valid, busy, done drop to 0 immediately; after release, pat_ready=1 and a new pattern transfers correctly.
- pat_valid held high continuously with changing pat_data -> a new pattern is accepted only in IDLE cycles; data driven while busy never appears on ser_out.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern serializer: default sizes, state encoding
// and the pattern-length clamp.
package pattern_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_LEN_W      = 4;
    localparam int DEF_REP_W      = 3;
    localparam int DEF_GAP_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        ZERO  = 2'd3
    } state_e;

    // Requests longer than the data register are trimmed to the full register.
    function automatic int clamp_len(input int len, input int max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/pattern_shift_reg.sv
// Loadable MSB-first shift register with a bits-remaining counter. It keeps a
// copy of the pattern so that later repetitions can be replayed.
module pattern_shift_reg
    import pattern_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              reload,
    input  logic              advance,
    input  logic [DATA_W-1:0] load_data,
    input  logic [LEN_W-1:0]  load_len,
    output logic              last,
    output logic              next_bit,
    output logic              next_last
);

    logic [DATA_W-1:0] pat_q, pat_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] aligned;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;

    // The pattern is left-aligned so the bit on the line is always the top bit.
    always_comb begin
        aligned = load_data << (DATA_W - int'(load_len));
        pat_d   = pat_q;
        len_d   = len_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load) begin
            pat_d   = aligned;
            len_d   = load_len;
            shift_d = aligned;
            cnt_d   = load_len;
        end else if (reload) begin
            shift_d = pat_q;
            cnt_d   = len_q;
        end else if (advance) begin
            shift_d = shift_q << 1;
            cnt_d   = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q   <= '0;
            len_q   <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign last      = (cnt_q == LEN_W'(1));
    assign next_last = (cnt_d == LEN_W'(1));
    assign next_bit  = shift_d[DATA_W-1];

endmodule

// File: rtl/pattern_serializer.sv
// Serializes a programmable-length pattern MSB-first with optional repeats
// separated by idle gap cycles. All outputs except pat_ready are registered.
module pattern_serializer
    import pattern_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int REP_W      = DEF_REP_W,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pat_valid,
    output logic              pat_ready,
    input  logic [DATA_W-1:0] pat_data,
    input  logic [LEN_W-1:0]  pat_len,
    input  logic [REP_W-1:0]  pat_rep,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_last,
    output logic              busy,
    output logic              done
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e            state_q, state_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              ser_out_q, ser_out_d;
    logic              ser_valid_q, ser_valid_d;
    logic              ser_last_q, ser_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sr_load, sr_reload, sr_advance;
    logic              sr_last, sr_next_bit, sr_next_last;
    logic [LEN_W-1:0]  len_clamped;
    logic              accept;

    assign len_clamped = LEN_W'(clamp_len(int'(pat_len), DATA_W));
    assign pat_ready   = (state_q == IDLE);
    assign accept      = pat_valid && pat_ready;

    pattern_shift_reg #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_shift (
        .clk       (clk),
        .reset     (reset),
        .load      (sr_load),
        .reload    (sr_reload),
        .advance   (sr_advance),
        .load_data (pat_data),
        .load_len  (len_clamped),
        .last      (sr_last),
        .next_bit  (sr_next_bit),
        .next_last (sr_next_last)
    );

    // Outputs are decoded from the next state so they line up with the
    // shift-register contents they describe.
    always_comb begin
        state_d    = state_q;
        rep_d      = rep_q;
        gap_d      = gap_q;
        sr_load    = 1'b0;
        sr_reload  = 1'b0;
        sr_advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rep_d = pat_rep;
                    if (len_clamped == '0) begin
                        state_d = ZERO;
                    end else begin
                        state_d = SHIFT;
                        sr_load = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (!sr_last) begin
                    sr_advance = 1'b1;
                end else if (rep_q != '0) begin
                    if (GAP_CYCLES == 0) begin
                        sr_reload = 1'b1;
                        rep_d     = rep_q - 1'b1;
                    end else begin
                        state_d = GAP;
                        gap_d   = GAP_LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d   = SHIFT;
                    sr_reload = 1'b1;
                    rep_d     = rep_q - 1'b1;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            ZERO:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ser_valid_d = (state_d == SHIFT);
        ser_out_d   = ser_valid_d && sr_next_bit;
        ser_last_d  = ser_valid_d && sr_next_last && (rep_d == '0);
        done_d      = ser_last_d || (state_d == ZERO);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rep_q       <= '0;
            gap_q       <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rep_q       <= rep_d;
            gap_q       <= gap_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ser_last_q  <= ser_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign ser_last  = ser_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Self-checking bench for pattern_serializer: directed transfers with a
// scoreboard of expected serial bits and per-transfer timing checks.
module tb_pattern_serializer;

    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pat_valid = 1'b0;
    logic       pat_ready;
    logic [7:0] pat_data = '0;
    logic [3:0] pat_len = '0;
    logic [2:0] pat_rep = '0;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_last;
    logic       busy;
    logic       done;

    int         checks = 0;
    int         failures = 0;
    logic [1:0] exp_q[$];
    logic [1:0] mon_item;
    bit         mon_en = 1'b0;

    pattern_serializer #(
        .DATA_W     (8),
        .LEN_W      (4),
        .REP_W      (3),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pat_valid (pat_valid),
        .pat_ready (pat_ready),
        .pat_data  (pat_data),
        .pat_len   (pat_len),
        .pat_rep   (pat_rep),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_last  (ser_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard entries are {bit, last-bit-of-transfer}.
    task automatic push_model(input logic [7:0] d, input int len, input int rep);
        int l;
        l = (len > 8) ? 8 : len;
        for (int r = 0; r <= rep; r++) begin
            for (int i = l - 1; i >= 0; i--) begin
                exp_q.push_back({d[i], 1'((r == rep) && (i == 0))});
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (ser_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(ser_valid), 0);
                end else begin
                    mon_item = exp_q.pop_front();
                    check("ser_out", 32'(ser_out), 32'(mon_item[1]));
                    check("ser_last", 32'(ser_last), 32'(mon_item[0]));
                    check("done_with_last", 32'(done), 32'(mon_item[0]));
                end
            end else begin
                check("idle_ser_out", 32'(ser_out), 0);
                check("idle_ser_last", 32'(ser_last), 0);
            end
        end
    end

    task automatic transfer(input logic [7:0] d, input int len, input int rep, input string tag);
        int l;
        int exp_busy;
        int busy_cycles;
        int valid_cycles;
        int dones;
        int done_at;
        bit accepted;
        l = (len > 8) ? 8 : len;
        exp_busy = (l == 0) ? 1 : (rep + 1) * l + rep * GAP;
        @(posedge clk);
        #1;
        pat_valid = 1'b1;
        pat_data  = d;
        pat_len   = 4'(len);
        pat_rep   = 3'(rep);
        push_model(d, len, rep);
        accepted = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (pat_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            check({tag, "_ready_timeout"}, 32'(pat_ready), 1);
            pat_valid = 1'b0;
            exp_q.delete();
            return;
        end
        @(posedge clk);
        #1;
        pat_valid = 1'b0;
        pat_data  = ~d;
        pat_len   = 4'(3);
        pat_rep   = 3'(5);
        busy_cycles  = 0;
        valid_cycles = 0;
        dones        = 0;
        done_at      = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cycles++;
            if (ser_valid) valid_cycles++;
            if (done) begin
                dones++;
                done_at = busy_cycles;
            end
        end
        check({tag, "_busy_cycles"}, busy_cycles, exp_busy);
        check({tag, "_valid_cycles"}, valid_cycles, (l == 0) ? 0 : (rep + 1) * l);
        check({tag, "_done_count"}, dones, 1);
        check({tag, "_done_at"}, done_at, exp_busy);
        check({tag, "_ready_after"}, 32'(pat_ready), 1);
        check({tag, "_sb_drain"}, exp_q.size(), 0);
    endtask

    initial begin
        int accepts;

        #2;
        check("rst_ready", 32'(pat_ready), 1);
        check("rst_ser_out", 32'(ser_out), 0);
        check("rst_ser_valid", 32'(ser_valid), 0);
        check("rst_ser_last", 32'(ser_last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        #10;
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;

        transfer(8'h09, 4, 0, "basic");
        transfer(8'h05, 3, 2, "repeat_gap");
        transfer(8'h00, 0, 3, "zero_len");
        transfer(8'hA5, 12, 0, "clamp");
        transfer(8'h01, 1, 1, "len_one");
        transfer(8'h02, 2, 7, "max_rep");
        transfer(8'h6C, 8, 1, "full_width");

        // Abort a transfer with an asynchronous reset in its second cycle.
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        pat_valid = 1'b1;
        pat_data  = 8'h0F;
        pat_len   = 4'd4;
        pat_rep   = 3'd0;
        @(posedge clk);
        #1;
        pat_valid = 1'b0;
        @(posedge clk);
        #3;
        check("abort_pre_busy", 32'(busy), 1);
        check("abort_pre_valid", 32'(ser_valid), 1);
        reset = 1'b0;
        #1;
        check("abort_ser_valid", 32'(ser_valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_ser_out", 32'(ser_out), 0);
        check("abort_ready", 32'(pat_ready), 1);
        #20;
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        mon_en = 1'b1;
        transfer(8'h0B, 4, 0, "post_reset");

        // Held request with data changing every cycle.
        accepts = 0;
        pat_len = 4'd4;
        pat_rep = 3'd0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            pat_valid = 1'b1;
            pat_data  = 8'($urandom);
            if (pat_ready) begin
                push_model(pat_data, 4, 0);
                accepts++;
            end
        end
        @(posedge clk);
        #1;
        pat_valid = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("held_idle", 32'(busy), 0);
        check("held_sb_drain", exp_q.size(), 0);
        check("held_accepts", 32'(accepts >= 3), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
